// File: rtl/cache_controller_if.sv
// Request, SRAM and cache-array signals of the cache controller, bundled in one interface.
// The slave modport is the controller's view; the master modport is the surrounding system.
interface cache_controller_if;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LINE_W  = 64;
  localparam int unsigned CADDR_W = 17;
  localparam int unsigned CNT_W   = 16;

  // memory-stage request
  logic                mem_r_en;
  logic                mem_w_en;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  // SRAM controller side
  logic                sram_r_en;
  logic                sram_w_en;
  logic [ADDR_W-1:0]   sram_address;
  logic [DATA_W-1:0]   sram_wdata;
  logic [LINE_W-1:0]   sram_rdata;
  logic                sram_ready;

  // cache array side
  logic                cache_read_en;
  logic                cache_write_en;
  logic                cache_is_store;
  logic [CADDR_W-1:0]  cache_address;
  logic [LINE_W-1:0]   cache_sram_data;
  logic [DATA_W-1:0]   cache_read_data;
  logic                cache_hit;

  // load performance counters
  logic [CNT_W-1:0]    hit_count;
  logic [CNT_W-1:0]    miss_count;

  modport slave (
    input  mem_r_en, mem_w_en, address, wdata,
    output rdata, ready,
    output sram_r_en, sram_w_en, sram_address, sram_wdata,
    input  sram_rdata, sram_ready,
    output cache_read_en, cache_write_en, cache_is_store, cache_address, cache_sram_data,
    input  cache_read_data, cache_hit,
    output hit_count, miss_count
  );

  modport master (
    output mem_r_en, mem_w_en, address, wdata,
    input  rdata, ready,
    input  sram_r_en, sram_w_en, sram_address, sram_wdata,
    output sram_rdata, sram_ready,
    input  cache_read_en, cache_write_en, cache_is_store, cache_address, cache_sram_data,
    output cache_read_data, cache_hit,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// Cache controller: zero-latency load hits, blocking line fills from SRAM on a load miss,
// write-through no-allocate stores, saturating hit/miss counters.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  cache_controller_if.slave bus
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LINE_W  = 64;
  localparam int unsigned CADDR_W = 17;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MISS_WAIT  = 2'd1,
    FILL       = 2'd2,
    WRITE_WAIT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [LINE_W-1:0]    r_line;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [CNT_W-1:0]     r_miss_cnt;
  logic                 w_hit_inc;
  logic                 w_miss_inc;
  logic                 w_line_load;
  logic [DATA_W-1:0]    w_offset;
  logic [CADDR_W-1:0]   w_cache_addr;
  logic [12:0]          w_unused_offset_hi;
  logic [1:0]           w_unused_offset_lo;

  // Word index of the request inside the cacheable window
  assign w_offset = bus.address - BASE_ADDR;
  assign {w_unused_offset_hi, w_cache_addr, w_unused_offset_lo} = w_offset;

  assign bus.cache_address   = w_cache_addr;
  assign bus.sram_address    = bus.address;
  assign bus.sram_wdata      = bus.wdata;
  assign bus.cache_sram_data = rst ? r_line     : '0;
  assign bus.hit_count       = rst ? r_hit_cnt  : '0;
  assign bus.miss_count      = rst ? r_miss_cnt : '0;

  // State, fill line and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_line     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_line_load) begin
        r_line <= bus.sram_rdata;
      end
      if (w_hit_inc && (r_hit_cnt != CNT_MAX)) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
      if (w_miss_inc && (r_miss_cnt != CNT_MAX)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  // Next state, strobes, ready and load data
  always_comb begin
    w_next             = r_state;
    w_hit_inc          = 1'b0;
    w_miss_inc         = 1'b0;
    w_line_load        = 1'b0;
    bus.ready          = 1'b0;
    bus.rdata          = '0;
    bus.sram_r_en      = 1'b0;
    bus.sram_w_en      = 1'b0;
    bus.cache_read_en  = 1'b0;
    bus.cache_write_en = 1'b0;
    bus.cache_is_store = 1'b0;

    case (r_state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.mem_w_en) begin
          // store wins over a simultaneous load; the cache drops the line on a hit
          bus.cache_is_store = 1'b1;
          bus.sram_w_en      = 1'b1;
          bus.ready          = 1'b0;
          w_next             = WRITE_WAIT;
        end else if (bus.mem_r_en) begin
          bus.cache_read_en = 1'b1;
          if (bus.cache_hit) begin
            bus.rdata = bus.cache_read_data;
            w_hit_inc = 1'b1;
          end else begin
            bus.sram_r_en = 1'b1;
            bus.ready     = 1'b0;
            w_miss_inc    = 1'b1;
            w_next        = MISS_WAIT;
          end
        end
      end

      MISS_WAIT: begin
        bus.sram_r_en = 1'b1;
        if (bus.sram_ready) begin
          w_line_load = 1'b1;
          w_next      = FILL;
        end
      end

      FILL: begin
        bus.cache_write_en = 1'b1;
        bus.ready          = 1'b1;
        bus.rdata          = w_cache_addr[0] ? r_line[63:32] : r_line[31:0];
        w_next             = IDLE;
      end

      WRITE_WAIT: begin
        bus.sram_w_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          w_next    = IDLE;
        end
      end

      default: w_next = IDLE;
    endcase

    // reset overrides everything and aborts any transfer in flight
    if (!rst) begin
      w_next             = IDLE;
      w_hit_inc          = 1'b0;
      w_miss_inc         = 1'b0;
      w_line_load        = 1'b0;
      bus.ready          = 1'b1;
      bus.rdata          = '0;
      bus.sram_r_en      = 1'b0;
      bus.sram_w_en      = 1'b0;
      bus.cache_read_en  = 1'b0;
      bus.cache_write_en = 1'b0;
      bus.cache_is_store = 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed transactions, a transaction-level expectation of
// every output per cycle, and literal checks on the headline scenarios.
module tb_cache_controller;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus();

  cache_controller #(.BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int mdl_hits   = 0;
  int mdl_misses = 0;

  // per-cycle expectation, set by the transaction tasks
  logic        chk_on = 1'b0;
  logic        e_ready, e_sram_r, e_sram_w, e_crd, e_cwr, e_cst, e_force;
  logic        e_rdata_vld, e_line_vld;
  logic [31:0] e_rdata;
  logic [63:0] e_line;

  // observations used by the literal checks
  int          lo_cnt, cwr_cnt, cst_cnt;
  logic [31:0] last_rdata;
  logic [16:0] last_caddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [16:0] exp_caddr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 17'(off >> 2);
  endfunction

  task automatic exp_idle();
    e_ready = 1'b1; e_sram_r = 1'b0; e_sram_w = 1'b0;
    e_crd = 1'b0; e_cwr = 1'b0; e_cst = 1'b0; e_force = 1'b0;
    e_rdata_vld = 1'b0; e_rdata = '0;
    e_line_vld = 1'b0; e_line = '0;
  endtask

  task automatic exp_reset();
    exp_idle();
    e_force     = 1'b1;
    e_rdata_vld = 1'b1;
    e_line_vld  = 1'b1;
  endtask

  task automatic drop_req();
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.cache_hit = 1'b0; bus.sram_ready = 1'b0;
    exp_idle();
  endtask

  task automatic clr_caps();
    lo_cnt = 0; cwr_cnt = 0; cst_cnt = 0;
  endtask

  task automatic drive_cycle();
    @(negedge clk);
    if (!bus.ready) lo_cnt++;
    if (bus.cache_write_en) cwr_cnt++;
    if (bus.cache_is_store) cst_cnt++;
    last_rdata = bus.rdata;
    last_caddr = bus.cache_address;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expectation once per cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready",          64'(bus.ready),          64'(e_ready));
      chk("sram_r_en",      64'(bus.sram_r_en),      64'(e_sram_r));
      chk("sram_w_en",      64'(bus.sram_w_en),      64'(e_sram_w));
      chk("cache_read_en",  64'(bus.cache_read_en),  64'(e_crd));
      chk("cache_write_en", 64'(bus.cache_write_en), 64'(e_cwr));
      chk("cache_is_store", 64'(bus.cache_is_store), 64'(e_cst));
      chk("sram_address",   64'(bus.sram_address),   64'(bus.address));
      chk("sram_wdata",     64'(bus.sram_wdata),     64'(bus.wdata));
      chk("cache_address",  64'(bus.cache_address),  64'(exp_caddr(bus.address)));
      chk("hit_count",  64'(bus.hit_count),  64'(e_force ? 16'd0 : sat16(mdl_hits)));
      chk("miss_count", 64'(bus.miss_count), 64'(e_force ? 16'd0 : sat16(mdl_misses)));
      if (e_rdata_vld) chk("rdata", 64'(bus.rdata), 64'(e_rdata));
      if (e_line_vld)  chk("cache_sram_data", bus.cache_sram_data, e_line);
    end
  end

  task automatic t_hit(input logic [31:0] addr, input logic [31:0] data);
    bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0; bus.address = addr;
    bus.cache_hit = 1'b1; bus.cache_read_data = data; bus.sram_ready = 1'b0;
    exp_idle(); e_crd = 1'b1; e_rdata_vld = 1'b1; e_rdata = data;
    drive_cycle();
    mdl_hits++;
    drop_req();
  endtask

  task automatic t_miss(input logic [31:0] addr, input int delay, input logic [63:0] line,
                        input logic early_pulse);
    logic [31:0] off;
    off = addr - BASE;
    bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0; bus.address = addr;
    bus.cache_hit = 1'b0; bus.sram_ready = early_pulse; bus.sram_rdata = ~line;
    exp_idle(); e_ready = 1'b0; e_crd = 1'b1; e_sram_r = 1'b1;
    drive_cycle();
    mdl_misses++;
    for (int k = 1; k <= delay; k++) begin
      bus.sram_ready = (k == delay); bus.sram_rdata = line; bus.cache_hit = 1'b1;
      exp_idle(); e_ready = 1'b0; e_sram_r = 1'b1;
      drive_cycle();
    end
    bus.sram_ready = 1'b0; bus.sram_rdata = '0;
    exp_idle(); e_cwr = 1'b1; e_rdata_vld = 1'b1;
    e_rdata = off[2] ? line[63:32] : line[31:0];
    e_line_vld = 1'b1; e_line = line;
    drive_cycle();
    drop_req();
  endtask

  task automatic t_store(input logic [31:0] addr, input logic [31:0] data, input logic hit,
                         input logic with_read, input int delay);
    bus.mem_w_en = 1'b1; bus.mem_r_en = with_read; bus.address = addr; bus.wdata = data;
    bus.cache_hit = hit; bus.cache_read_data = 32'hBAD0_BAD0; bus.sram_ready = 1'b0;
    exp_idle(); e_ready = 1'b0; e_cst = 1'b1; e_sram_w = 1'b1;
    drive_cycle();
    for (int k = 1; k <= delay; k++) begin
      bus.sram_ready = (k == delay);
      exp_idle(); e_sram_w = 1'b1; e_ready = (k == delay);
      drive_cycle();
    end
    drop_req();
  endtask

  task automatic t_reset_abort(input logic is_store);
    clr_caps();
    bus.address = 32'h0000_0410; bus.wdata = 32'h1234_5678;
    bus.mem_r_en = !is_store; bus.mem_w_en = is_store;
    bus.cache_hit = 1'b0; bus.sram_ready = 1'b0;
    exp_idle(); e_ready = 1'b0;
    e_cst = is_store; e_sram_w = is_store; e_crd = !is_store; e_sram_r = !is_store;
    drive_cycle();
    if (!is_store) mdl_misses++;
    e_crd = 1'b0; e_cst = 1'b0;
    drive_cycle();
    rst = 1'b0; exp_reset();
    drive_cycle();
    mdl_hits = 0; mdl_misses = 0;
    rst = 1'b1; drop_req();
    bus.sram_ready = 1'b1; bus.sram_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    drive_cycle();
    bus.sram_ready = 1'b0;
    drive_cycle();
    chk("abort_no_fill", 64'(cwr_cnt), 64'd0);
    chk("abort_hit_count", 64'(bus.hit_count), 64'd0);
    chk("abort_miss_count", 64'(bus.miss_count), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.address = 32'h0000_0400; bus.wdata = '0;
    bus.sram_rdata = '0; bus.sram_ready = 1'b0;
    bus.cache_read_data = '0; bus.cache_hit = 1'b0;
    exp_reset();
    chk_on = 1'b1;
    clr_caps();
    for (int i = 0; i < 3; i++) drive_cycle();

    // idle with a stray sram_ready
    rst = 1'b1; drop_req();
    bus.sram_ready = 1'b1;
    drive_cycle();
    bus.sram_ready = 1'b0;
    drive_cycle();

    // load hit at the base address
    clr_caps();
    t_hit(32'h0000_0400, 32'hDEAD_BEEF);
    chk("hit_rdata", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("hit_caddr", 64'(last_caddr), 64'd0);
    chk("hit_no_stall", 64'(lo_cnt), 64'd0);
    chk("hit_count_1", 64'(bus.hit_count), 64'd1);

    // load miss, odd word, sram_ready after five wait cycles
    clr_caps();
    t_miss(32'h0000_0404, 5, 64'h1111_1111_2222_2222, 1'b0);
    chk("miss_stall_cycles", 64'(lo_cnt), 64'd6);
    chk("miss_fill_once", 64'(cwr_cnt), 64'd1);
    chk("miss_rdata", 64'(last_rdata), 64'h0000_0000_1111_1111);
    chk("miss_caddr", 64'(last_caddr), 64'd1);
    chk("miss_count_1", 64'(bus.miss_count), 64'd1);

    // even word miss with sram_ready also pulsed on the issue cycle
    clr_caps();
    t_miss(32'h0000_1408, 1, 64'hCAFE_F00D_0BAD_C0DE, 1'b1);
    chk("miss2_stall_cycles", 64'(lo_cnt), 64'd2);
    chk("miss2_rdata", 64'(last_rdata), 64'h0000_0000_0BAD_C0DE);

    // store hit, write-through, no fill
    clr_caps();
    t_store(32'h0000_0408, 32'hA5A5_A5A5, 1'b1, 1'b0, 3);
    chk("store_is_store_once", 64'(cst_cnt), 64'd1);
    chk("store_no_fill", 64'(cwr_cnt), 64'd0);
    chk("store_stall_cycles", 64'(lo_cnt), 64'd3);

    // load and store together: store path, counters untouched
    clr_caps();
    t_store(32'h0000_040C, 32'h5A5A_5A5A, 1'b0, 1'b1, 1);
    chk("rw_hit_count", 64'(bus.hit_count), 64'd1);
    chk("rw_miss_count", 64'(bus.miss_count), 64'd2);

    // address offsets beyond the 17-bit index and below the base
    t_hit(BASE + 32'h0008_0004, 32'h0123_4567);
    t_hit(32'h0000_0000, 32'h89AB_CDEF);
    t_miss(32'h0000_0000, 2, 64'h7777_6666_5555_4444, 1'b0);

    // reset while a miss, then a store, is outstanding
    t_reset_abort(1'b0);
    t_reset_abort(1'b1);

    // hit counter saturation
    for (int i = 0; i < 65537; i++) t_hit(32'h0000_0400 + 32'(i[3:0]) * 4, 32'(i));
    chk("sat_hit_count", 64'(bus.hit_count), 64'h0000_0000_0000_FFFF);
    t_hit(32'h0000_0400, 32'h0000_0001);
    chk("sat_hold", 64'(bus.hit_count), 64'h0000_0000_0000_FFFF);
    t_miss(32'h0000_0404, 1, 64'h0000_0002_0000_0003, 1'b0);
    chk("sat_miss_count", 64'(bus.miss_count), 64'd1);

    drive_cycle();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
